id_ex_issue: RTL and testbench

//  Operand-issue stage and ID/EX pipeline register that drives the execute ALU.

---
 rtl/alu_pkg.sv | 19 +
 rtl/fwd_mux.sv | 28 ++
 rtl/id_ex_issue.sv | 142 ++++++++++++++
 tb/tb_id_ex_issue.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types for the issue stage and the execute ALU it feeds.
package alu_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int REG_AW_DEF = 5;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_OR  = 2'b11
    } alu_op_t;

    typedef enum logic {
        RUN    = 1'b0,
        BUBBLE = 1'b1
    } issue_state_t;

endpackage

// File: rtl/fwd_mux.sv
// Per-source operand forwarding: r0 wins, then EX, MEM and WB in that order, then the regfile read.
module fwd_mux #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] src_i,
    input  logic [DATA_W-1:0] id_val_i,
    input  logic              ex_en_i,
    input  logic [REG_AW-1:0] ex_rd_i,
    input  logic [DATA_W-1:0] ex_val_i,
    input  logic              mem_en_i,
    input  logic [REG_AW-1:0] mem_rd_i,
    input  logic [DATA_W-1:0] mem_val_i,
    input  logic              wb_en_i,
    input  logic [REG_AW-1:0] wb_rd_i,
    input  logic [DATA_W-1:0] wb_val_i,
    output logic [DATA_W-1:0] fwd_o
);

    always_comb begin
        fwd_o = id_val_i;
        if (src_i == '0)                            fwd_o = '0;
        else if (ex_en_i  && (ex_rd_i  == src_i))   fwd_o = ex_val_i;
        else if (mem_en_i && (mem_rd_i == src_i))   fwd_o = mem_val_i;
        else if (wb_en_i  && (wb_rd_i  == src_i))   fwd_o = wb_val_i;
    end

endmodule

// File: rtl/id_ex_issue.sv
// Operand-issue stage: forwarding, load-use bubble FSM and the ID/EX register feeding execute.
module id_ex_issue
    import alu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int REG_AW = REG_AW_DEF,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic [DATA_W-1:0] id_rsVal,
    input  logic [DATA_W-1:0] id_rtVal,
    input  logic [15:0]       id_imm,
    input  logic              id_aluSrc,
    input  logic [1:0]        id_ctrl,
    input  logic              id_regWrite,
    input  logic              id_memRead,
    input  logic              flush,
    input  logic [DATA_W-1:0] EXaluOut,
    input  logic              mem_regWrite,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic [DATA_W-1:0] mem_result,
    input  logic              wb_regWrite,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [DATA_W-1:0] wb_data,
    output logic [DATA_W-1:0] aluSrcA,
    output logic [DATA_W-1:0] aluSrcB,
    output logic [1:0]        ctrl,
    output logic              ex_valid,
    output logic [REG_AW-1:0] ex_rd,
    output logic              ex_regWrite,
    output logic              ex_memRead,
    output logic [DATA_W-1:0] ex_rtVal,
    output logic              stall,
    output logic [CNT_W-1:0]  stall_cnt
);

    issue_state_t      state_q;
    logic [DATA_W-1:0] srcA_q, srcB_q, rtVal_q;
    logic [1:0]        ctrl_q;
    logic              valid_q, regWrite_q, memRead_q;
    logic [REG_AW-1:0] rd_q;
    logic [CNT_W-1:0]  cnt_q;

    logic [DATA_W-1:0] rs_fwd, rt_fwd, srcB_d;
    logic              ex_fwd_en, hazard, load_bubble;

    // A load in EX has no result yet, so it is never an EX forwarding source.
    assign ex_fwd_en = valid_q & regWrite_q & ~memRead_q;

    fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rs (
        .src_i    (id_rs),
        .id_val_i (id_rsVal),
        .ex_en_i  (ex_fwd_en),
        .ex_rd_i  (rd_q),
        .ex_val_i (EXaluOut),
        .mem_en_i (mem_regWrite),
        .mem_rd_i (mem_rd),
        .mem_val_i(mem_result),
        .wb_en_i  (wb_regWrite),
        .wb_rd_i  (wb_rd),
        .wb_val_i (wb_data),
        .fwd_o    (rs_fwd)
    );

    fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rt (
        .src_i    (id_rt),
        .id_val_i (id_rtVal),
        .ex_en_i  (ex_fwd_en),
        .ex_rd_i  (rd_q),
        .ex_val_i (EXaluOut),
        .mem_en_i (mem_regWrite),
        .mem_rd_i (mem_rd),
        .mem_val_i(mem_result),
        .wb_en_i  (wb_regWrite),
        .wb_rd_i  (wb_rd),
        .wb_val_i (wb_data),
        .fwd_o    (rt_fwd)
    );

    assign srcB_d = id_aluSrc ? {{(DATA_W-16){id_imm[15]}}, id_imm} : rt_fwd;

    // rt only matters for the hazard when it is actually used as operand B.
    assign hazard = (state_q == RUN) & id_valid & valid_q & memRead_q & (rd_q != '0) &
                    ((rd_q == id_rs) | ((rd_q == id_rt) & ~id_aluSrc));

    assign stall       = hazard & ~flush;
    assign load_bubble = flush | ~id_valid | hazard;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= RUN;
            srcA_q     <= '0;
            srcB_q     <= '0;
            rtVal_q    <= '0;
            ctrl_q     <= ALU_ADD;
            valid_q    <= 1'b0;
            rd_q       <= '0;
            regWrite_q <= 1'b0;
            memRead_q  <= 1'b0;
            cnt_q      <= '0;
        end else begin
            if (load_bubble) begin
                srcA_q     <= '0;
                srcB_q     <= '0;
                rtVal_q    <= '0;
                ctrl_q     <= ALU_ADD;
                valid_q    <= 1'b0;
                rd_q       <= '0;
                regWrite_q <= 1'b0;
                memRead_q  <= 1'b0;
            end else begin
                srcA_q     <= rs_fwd;
                srcB_q     <= srcB_d;
                rtVal_q    <= rt_fwd;
                ctrl_q     <= id_ctrl;
                valid_q    <= 1'b1;
                rd_q       <= id_rd;
                regWrite_q <= id_regWrite;
                memRead_q  <= id_memRead;
            end
            state_q <= stall ? BUBBLE : RUN;
            if (stall && (cnt_q != '1))
                cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign aluSrcA     = srcA_q;
    assign aluSrcB     = srcB_q;
    assign ctrl        = ctrl_q;
    assign ex_valid    = valid_q;
    assign ex_rd       = rd_q;
    assign ex_regWrite = regWrite_q;
    assign ex_memRead  = memRead_q;
    assign ex_rtVal    = rtVal_q;
    assign stall_cnt   = cnt_q;

endmodule

// File: tb/tb_id_ex_issue.sv
// Directed bench for id_ex_issue: forwarding priority, load-use bubble, flush, counter saturation, async reset.
module tb_id_ex_issue;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          id_valid, id_aluSrc, id_regWrite, id_memRead, flush;
    logic [AW-1:0] id_rs, id_rt, id_rd, mem_rd, wb_rd;
    logic [DW-1:0] id_rsVal, id_rtVal, EXaluOut, mem_result, wb_data;
    logic [15:0]   id_imm;
    logic [1:0]    id_ctrl;
    logic          mem_regWrite, wb_regWrite;
    logic [DW-1:0] aluSrcA, aluSrcB, ex_rtVal;
    logic [1:0]    ctrl;
    logic          ex_valid, ex_regWrite, ex_memRead, stall;
    logic [AW-1:0] ex_rd;
    logic [CW-1:0] stall_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    id_ex_issue #(.DATA_W(DW), .REG_AW(AW), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_rsVal(id_rsVal), .id_rtVal(id_rtVal), .id_imm(id_imm),
        .id_aluSrc(id_aluSrc), .id_ctrl(id_ctrl), .id_regWrite(id_regWrite),
        .id_memRead(id_memRead), .flush(flush), .EXaluOut(EXaluOut),
        .mem_regWrite(mem_regWrite), .mem_rd(mem_rd), .mem_result(mem_result),
        .wb_regWrite(wb_regWrite), .wb_rd(wb_rd), .wb_data(wb_data),
        .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .ctrl(ctrl), .ex_valid(ex_valid),
        .ex_rd(ex_rd), .ex_regWrite(ex_regWrite), .ex_memRead(ex_memRead),
        .ex_rtVal(ex_rtVal), .stall(stall), .stall_cnt(stall_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ld_id(input logic v, input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                         input logic [AW-1:0] rd, input logic [DW-1:0] rsv,
                         input logic [DW-1:0] rtv, input logic [15:0] imm, input logic asrc,
                         input logic [1:0] ctl, input logic rw, input logic mr);
        id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd; id_rsVal = rsv; id_rtVal = rtv;
        id_imm = imm; id_aluSrc = asrc; id_ctrl = ctl; id_regWrite = rw; id_memRead = mr;
    endtask

    task automatic clr_fwd();
        EXaluOut = '0; mem_regWrite = 0; mem_rd = '0; mem_result = '0;
        wb_regWrite = 0; wb_rd = '0; wb_data = '0;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0;
        ld_id(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
        clr_fwd();
        #12 rst = 1'b0;
        chk("rst_valid", ex_valid, 0);
        chk("rst_cnt", stall_cnt, 0);

        // EX forward
        ld_id(1, 1, 2, 3, 32'h100, 32'h200, 0, 0, 2'b00, 1, 0); step();
        EXaluOut = 32'h10;
        ld_id(1, 3, 0, 8, 32'h5, 0, 0, 0, 2'b00, 0, 0); step();
        chk("ex_fwd_A", aluSrcA, 32'h10);
        chk("ex_fwd_rd", ex_rd, 8);
        chk("ex_fwd_rt0", ex_rtVal, 0);

        // EX over MEM, then MEM when EX holds a bubble, then WB, then MEM over WB
        ld_id(1, 0, 0, 4, 0, 0, 0, 0, 2'b00, 1, 0); step();
        EXaluOut = 32'h7; mem_regWrite = 1; mem_rd = 4; mem_result = 32'h9;
        ld_id(1, 4, 0, 9, 32'h33, 0, 0, 0, 2'b00, 0, 0); step();
        chk("prio_ex", aluSrcA, 32'h7);
        ld_id(0, 4, 0, 9, 32'h33, 0, 0, 0, 2'b00, 0, 0); step();
        chk("bubble_valid", ex_valid, 0);
        chk("bubble_A", aluSrcA, 0);
        ld_id(1, 4, 0, 9, 32'h33, 0, 0, 0, 2'b00, 0, 0); step();
        chk("prio_mem", aluSrcA, 32'h9);
        mem_regWrite = 0; wb_regWrite = 1; wb_rd = 4; wb_data = 32'h55; step();
        chk("prio_wb", aluSrcA, 32'h55);
        mem_regWrite = 1; step();
        chk("prio_mem_wb", aluSrcA, 32'h9);
        clr_fwd();

        // Load-use
        ld_id(1, 0, 0, 2, 0, 0, 0, 0, 2'b00, 1, 1); step();
        ld_id(1, 2, 1, 5, 32'h1, 32'h77, 0, 0, 2'b00, 1, 0); #1;
        chk("lu_stall", stall, 1);
        step();
        chk("lu_bubble", ex_valid, 0);
        chk("lu_stall_drop", stall, 0);
        chk("lu_cnt", stall_cnt, 1);
        mem_regWrite = 1; mem_rd = 2; mem_result = 32'hDEADBEEF; step();
        chk("lu_issue_A", aluSrcA, 32'hDEADBEEF);
        chk("lu_issue_v", ex_valid, 1);
        chk("lu_rtval", ex_rtVal, 32'h77);
        chk("lu_no_stall", stall, 0);
        clr_fwd();

        // Immediate, load to rt with aluSrc does not stall
        ld_id(1, 0, 0, 6, 0, 0, 0, 0, 2'b00, 1, 1); step();
        ld_id(1, 0, 6, 10, 0, 32'h1234, 16'hFFFE, 1, 2'b01, 1, 0); #1;
        chk("imm_no_stall", stall, 0);
        step();
        chk("imm_B", aluSrcB, 32'hFFFFFFFE);
        chk("imm_ctrl", ctrl, 2'b01);
        chk("imm_rtval", ex_rtVal, 32'h1234);
        chk("imm_cnt", stall_cnt, 1);

        // Flush during hazard
        ld_id(1, 0, 0, 7, 0, 0, 0, 0, 2'b00, 1, 1); step();
        ld_id(1, 7, 0, 11, 0, 0, 0, 0, 2'b00, 1, 0); flush = 1; #1;
        chk("fl_stall", stall, 0);
        step();
        flush = 0;
        chk("fl_bubble", ex_valid, 0);
        chk("fl_cnt", stall_cnt, 1);

        // r0 never forwards
        ld_id(1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 1, 0); step();
        EXaluOut = 32'hAA; mem_regWrite = 1; mem_rd = 0; mem_result = 32'hBB;
        wb_regWrite = 1; wb_rd = 0; wb_data = 32'hCC;
        ld_id(1, 0, 0, 12, 32'h11, 32'h22, 0, 0, 2'b00, 1, 0); step();
        chk("r0_A", aluSrcA, 0);
        chk("r0_B", aluSrcB, 0);
        chk("r0_rt", ex_rtVal, 0);
        clr_fwd();

        // Counter saturation, alternating rs and rt hazards
        for (int i = 0; i < 8; i++) begin
            ld_id(1, 0, 0, 2, 0, 0, 0, 0, 2'b00, 1, 1); step();
            ld_id(1, (i % 2 == 0) ? 5'd2 : 5'd0, (i % 2 == 0) ? 5'd0 : 5'd2, 5, 0, 0, 0, 0,
                  2'b00, 1, 0); #1;
            chk("sat_stall", stall, 1);
            step(); step();
            if (i == 2) chk("sat_mid", stall_cnt, 4);
        end
        chk("sat_hold", stall_cnt, 7);

        // Async reset mid-stream
        ld_id(1, 0, 0, 3, 32'h99, 0, 0, 0, 2'b11, 1, 0); step();
        chk("pre_rst_v", ex_valid, 1);
        chk("pre_rst_ctrl", ctrl, 2'b11);
        #2 rst = 1'b1; #1;
        chk("arst_valid", ex_valid, 0);
        chk("arst_ctrl", ctrl, 2'b00);
        chk("arst_A", aluSrcA, 0);
        chk("arst_rw", ex_regWrite, 0);
        chk("arst_rd", ex_rd, 0);
        chk("arst_cnt", stall_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
